// File: rtl/mission_event_sequencer_pkg.sv
// Shared types for the mission event sequencer: FSM states, unit indices and unit flag decode.
package mission_event_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSearch,
        StPick,
        StCarry,
        StNext,
        StDone
    } seq_state_e;

    typedef logic [1:0] unit_t;

    localparam unit_t UnitEu = 2'd0;
    localparam unit_t UnitCu = 2'd1;
    localparam unit_t UnitRu = 2'd2;

    // Bit 0 = EU, bit 1 = CU, bit 2 = RU; unit value 3 decodes to no flag.
    function automatic logic [2:0] unit_flags(unit_t unit, logic active);
        logic [2:0] flags;
        flags = 3'b000;
        if (active) begin
            case (unit)
                UnitEu:  flags = 3'b001;
                UnitCu:  flags = 3'b010;
                UnitRu:  flags = 3'b100;
                default: flags = 3'b000;
            endcase
        end
        return flags;
    endfunction

endpackage

// File: rtl/mission_event_sequencer_if.sv
// Sensor/actuator inputs and LED-driver event flags of the mission event sequencer.
interface mission_event_sequencer_if;
    logic start;
    logic node_sense;
    logic fault_sense;
    logic pick_done;
    logic drop_done;
    logic node_flag;
    logic fault_detect;
    logic block_picked;
    logic object_drop;
    logic run_complete;
    logic EU_fault_flag;
    logic CU_fault_flag;
    logic RU_fault_flag;

    // Sequencer side: consumes sensors, produces event flags.
    modport master (
        input  start, node_sense, fault_sense, pick_done, drop_done,
        output node_flag, fault_detect, block_picked, object_drop, run_complete,
        output EU_fault_flag, CU_fault_flag, RU_fault_flag
    );

    modport slave (
        output start, node_sense, fault_sense, pick_done, drop_done,
        input  node_flag, fault_detect, block_picked, object_drop, run_complete,
        input  EU_fault_flag, CU_fault_flag, RU_fault_flag
    );
endinterface

// File: rtl/mission_event_sequencer_debouncer.sv
// Two-flop synchroniser plus counting debounce filter; rise_o is high for one cycle after the
// filtered level goes 0->1.
module mission_event_sequencer_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 3125
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic rise_o
);
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            filt_q, filt_d, filt_dly_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronised input disagrees with the filtered level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CntMax) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw_i;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            filt_dly_q <= filt_q;
            cnt_q      <= cnt_d;
        end
    end

    assign rise_o = filt_q & ~filt_dly_q;
endmodule

// File: rtl/mission_event_sequencer.sv
// Walks the EU, CU and RU units through search/pick/carry/drop and emits registered event flags
// for the RGB status LED driver.
module mission_event_sequencer
    import mission_event_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3125,
    parameter int unsigned NODE_LIMIT      = 8
) (
    input logic                              clk_3125KHz,
    input logic                              reset,
    mission_event_sequencer_if.master        seq_io
);
    localparam int unsigned CntW = $clog2(NODE_LIMIT + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(NODE_LIMIT);

    seq_state_e      state_q, state_d;
    unit_t           unit_q, unit_d;
    logic [CntW-1:0] node_cnt_q, node_cnt_d;
    logic            node_rise, fault_rise, in_unit;

    logic node_flag_q, node_flag_d;
    logic fault_detect_q, fault_detect_d;
    logic block_picked_q, block_picked_d;
    logic object_drop_q, object_drop_d;
    logic run_complete_q, run_complete_d;
    logic [2:0] unit_flags_q, unit_flags_d;

    mission_event_sequencer_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_node_deb (
        .clk_i (clk_3125KHz),
        .rst_i (reset),
        .raw_i (seq_io.node_sense),
        .rise_o(node_rise)
    );

    mission_event_sequencer_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fault_deb (
        .clk_i (clk_3125KHz),
        .rst_i (reset),
        .raw_i (seq_io.fault_sense),
        .rise_o(fault_rise)
    );

    assign in_unit = state_q inside {StSearch, StPick, StCarry};

    always_ff @(posedge clk_3125KHz) begin
        if (reset) begin
            state_q        <= StIdle;
            unit_q         <= UnitEu;
            node_cnt_q     <= '0;
            node_flag_q    <= 1'b0;
            fault_detect_q <= 1'b0;
            block_picked_q <= 1'b0;
            object_drop_q  <= 1'b0;
            run_complete_q <= 1'b0;
            unit_flags_q   <= 3'b000;
        end else begin
            state_q        <= state_d;
            unit_q         <= unit_d;
            node_cnt_q     <= node_cnt_d;
            node_flag_q    <= node_flag_d;
            fault_detect_q <= fault_detect_d;
            block_picked_q <= block_picked_d;
            object_drop_q  <= object_drop_d;
            run_complete_q <= run_complete_d;
            unit_flags_q   <= unit_flags_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        node_cnt_d = node_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (seq_io.start) begin
                    state_d    = StSearch;
                    unit_d     = UnitEu;
                    node_cnt_d = '0;
                end
            end
            StSearch: begin
                if (node_rise && (node_cnt_q != CntLimit)) begin
                    node_cnt_d = node_cnt_q + CntW'(1);
                end
                // A fault beats the node-limit skip when both land in the same cycle.
                if (fault_rise) begin
                    state_d = StPick;
                end else if (node_cnt_q == CntLimit) begin
                    state_d = StNext;
                end
            end
            StPick:  if (seq_io.pick_done) state_d = StCarry;
            StCarry: if (seq_io.drop_done) state_d = StNext;
            StNext: begin
                if (unit_q == UnitRu) begin
                    state_d = StDone;
                end else begin
                    state_d    = StSearch;
                    unit_d     = unit_q + 2'd1;
                    node_cnt_d = '0;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Unit flags decode the next state so they line up with the registered state.
    always_comb begin
        node_flag_d    = node_rise & in_unit;
        fault_detect_d = fault_rise & (state_q == StSearch);
        block_picked_d = seq_io.pick_done & (state_q == StPick);
        object_drop_d  = seq_io.drop_done & (state_q == StCarry);
        run_complete_d = run_complete_q | (state_d == StDone);
        unit_flags_d   = unit_flags(unit_d, state_d inside {StSearch, StPick, StCarry});
    end

    assign seq_io.node_flag     = node_flag_q;
    assign seq_io.fault_detect  = fault_detect_q;
    assign seq_io.block_picked  = block_picked_q;
    assign seq_io.object_drop   = object_drop_q;
    assign seq_io.run_complete  = run_complete_q;
    assign seq_io.EU_fault_flag = unit_flags_q[0];
    assign seq_io.CU_fault_flag = unit_flags_q[1];
    assign seq_io.RU_fault_flag = unit_flags_q[2];
endmodule
